// File: rtl/clk_ctrl_pkg.sv
// Shared clocking-control definitions: sequencer state encoding and
// 200MHz cycle-count constants used by the board clock controllers.
package clk_ctrl_pkg;

    localparam int CLK_FREQ_HZ   = 200_000_000;
    localparam int CYCLES_PER_US = 200;
    localparam int CYCLES_PER_MS = 200_000;

    localparam logic [5:0] ST_HOLD      = 6'b000001;
    localparam logic [5:0] ST_WAIT_LOCK = 6'b000010;
    localparam logic [5:0] ST_STABLE    = 6'b000100;
    localparam logic [5:0] ST_RELEASE   = 6'b001000;
    localparam logic [5:0] ST_RUN       = 6'b010000;
    localparam logic [5:0] ST_FAIL      = 6'b100000;

    typedef enum logic [5:0] {
        HOLD      = ST_HOLD,
        WAIT_LOCK = ST_WAIT_LOCK,
        STABLE    = ST_STABLE,
        RELEASE   = ST_RELEASE,
        RUN       = ST_RUN,
        FAIL      = ST_FAIL
    } seq_state_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop bit synchroniser for a single asynchronous level input.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    // NOTE: ASYNC_REG keeps both flops packed together so the first one's
    // metastability window resolves before the second samples it.
    (* ASYNC_REG = "TRUE" *) logic [1:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) r_sync <= 2'b00;
        else       r_sync <= {r_sync[0], i_d};
    end

    assign o_q = r_sync[1];

endmodule

// File: rtl/mmcm_reset_sequencer.sv
// Board MMCM reset/lock supervisor: pulses MMCM reset, waits for a stable lock
// with bounded retries, then releases downstream reset domains in order.
module mmcm_reset_sequencer
    import clk_ctrl_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 7,
    parameter int N_DOMAINS     = 4,
    parameter int STAGGER       = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mmcm_locked,
    output logic                 mmcm_rst,
    output logic [N_DOMAINS-1:0] rst_out,
    output logic                 ready,
    output logic                 fail,
    output logic [7:0]           retry_cnt
);

    localparam int CNT_MAX = max4(LOCK_TIMEOUT, STABLE_CYCLES, RST_CYCLES, N_DOMAINS * STAGGER);
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'((N_DOMAINS - 1) * STAGGER);
    localparam logic [7:0]       RETRY_LIMIT  = 8'(MAX_RETRIES);

    seq_state_t           r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_mmcm_rst;
    logic [N_DOMAINS-1:0] r_rst_out;
    logic                 r_ready;
    logic                 r_fail;
    logic [7:0]           r_retry_cnt;

    logic                 w_lk_s;
    logic [CNT_W-1:0]     w_cnt_inc;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (mmcm_locked),
        .o_q   (w_lk_s)
    );

    assign w_cnt_inc = r_cnt + 1'b1;

    // NOTE: every state register uses <= so all of them update from the same
    // pre-edge values; a blocking assignment here would leak new values forward.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= HOLD;
            r_cnt       <= '0;
            r_mmcm_rst  <= 1'b1;
            r_rst_out   <= '1;
            r_ready     <= 1'b0;
            r_fail      <= 1'b0;
            r_retry_cnt <= '0;
        end else begin
            case (r_state)
                HOLD: begin
                    if (r_cnt == RST_LAST) begin
                        r_state    <= WAIT_LOCK;
                        r_cnt      <= '0;
                        r_mmcm_rst <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                WAIT_LOCK: begin
                    if (w_lk_s) begin
                        r_state <= STABLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        r_cnt      <= '0;
                        r_mmcm_rst <= 1'b1;
                        if (r_retry_cnt == RETRY_LIMIT) begin
                            r_state <= FAIL;
                            r_fail  <= 1'b1;
                        end else begin
                            r_state     <= HOLD;
                            r_retry_cnt <= r_retry_cnt + 8'd1;
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                // A drop here is a glitch, not a failed attempt: restart the timeout only.
                STABLE: begin
                    if (!w_lk_s) begin
                        r_state <= WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == STABLE_LAST) begin
                        r_state      <= RELEASE;
                        r_cnt        <= '0;
                        r_rst_out[0] <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                RELEASE: begin
                    if (!w_lk_s) begin
                        r_state    <= HOLD;
                        r_cnt      <= '0;
                        r_mmcm_rst <= 1'b1;
                        r_rst_out  <= '1;
                        r_ready    <= 1'b0;
                    end else if (r_cnt == RELEASE_LAST) begin
                        r_state     <= RUN;
                        r_cnt       <= '0;
                        r_ready     <= 1'b1;
                        r_retry_cnt <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        for (int i = 1; i < N_DOMAINS; i++) begin
                            if (w_cnt_inc == CNT_W'(i * STAGGER)) r_rst_out[i] <= 1'b0;
                        end
                    end
                end

                RUN: begin
                    if (!w_lk_s) begin
                        r_state    <= HOLD;
                        r_cnt      <= '0;
                        r_mmcm_rst <= 1'b1;
                        r_rst_out  <= '1;
                        r_ready    <= 1'b0;
                    end
                end

                FAIL: begin
                    r_mmcm_rst <= 1'b1;
                    r_rst_out  <= '1;
                    r_ready    <= 1'b0;
                    r_fail     <= 1'b1;
                end

                default: begin
                    r_state    <= HOLD;
                    r_cnt      <= '0;
                    r_mmcm_rst <= 1'b1;
                    r_rst_out  <= '1;
                    r_ready    <= 1'b0;
                end
            endcase
        end
    end

    assign mmcm_rst  = r_mmcm_rst;
    assign rst_out   = r_rst_out;
    assign ready     = r_ready;
    assign fail      = r_fail;
    assign retry_cnt = r_retry_cnt;

endmodule

// File: tb/tb_mmcm_reset_sequencer.sv
// Directed bench for mmcm_reset_sequencer: vector table of input phases with
// hand-computed outputs, a latency sequence, and continuous invariant monitors.
module tb_mmcm_reset_sequencer;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 2;
    localparam int N_DOMAINS     = 3;
    localparam int STAGGER       = 5;

    logic                 clk;
    logic                 reset;
    logic                 mmcm_locked;
    logic                 mmcm_rst;
    logic [N_DOMAINS-1:0] rst_out;
    logic                 ready;
    logic                 fail;
    logic [7:0]           retry_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      name;
        logic       rst;
        logic       lk;
        int         cycles;
        logic       mrst;
        logic [2:0] rout;
        logic       rdy;
        logic       fl;
        logic [7:0] rc;
    } vec_t;

    vec_t vecs[$];

    mmcm_reset_sequencer #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRIES   (MAX_RETRIES),
        .N_DOMAINS     (N_DOMAINS),
        .STAGGER       (STAGGER)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mmcm_locked (mmcm_locked),
        .mmcm_rst    (mmcm_rst),
        .rst_out     (rst_out),
        .ready       (ready),
        .fail        (fail),
        .retry_cnt   (retry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (mrst,rst_out,ready,fail,retry packed)", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic rst, input logic lk, input int cycles,
                       input logic mrst, input logic [2:0] rout, input logic rdy,
                       input logic fl, input logic [7:0] rc);
        vec_t v;
        v.name = name; v.rst = rst; v.lk = lk; v.cycles = cycles;
        v.mrst = mrst; v.rout = rout; v.rdy = rdy; v.fl = fl; v.rc = rc;
        vecs.push_back(v);
    endtask

    function automatic logic [31:0] pack_out(input logic m, input logic [2:0] r, input logic rd,
                                             input logic f, input logic [7:0] c);
        return {18'd0, m, r, rd, f, c};
    endfunction

    // Invariant monitors, evaluated mid-cycle while outputs are settled.
    logic       last_reset_edge = 1'b1;
    logic       prev_fail       = 1'b0;
    logic [2:0] prev_rout       = 3'b111;

    always @(posedge clk) last_reset_edge <= reset;

    always @(negedge clk) begin
        if (ready && (rst_out != 3'b000 || mmcm_rst || fail)) begin
            errors++;
            $display("FAIL ready_invariant: ready=%b rst_out=%b mmcm_rst=%b fail=%b", ready, rst_out, mmcm_rst, fail);
        end
        if (retry_cnt > 8'(MAX_RETRIES)) begin
            errors++;
            $display("FAIL retry_bound: retry_cnt=%0d limit=%0d", retry_cnt, MAX_RETRIES);
        end
        if (prev_fail && !fail && !last_reset_edge) begin
            errors++;
            $display("FAIL fail_sticky: fail dropped without reset");
        end
        if (((rst_out & ~prev_rout) != 3'b000) && rst_out != 3'b111) begin
            errors++;
            $display("FAIL partial_reassert: rst_out %b -> %b", prev_rout, rst_out);
        end
        if (((~rst_out) & ((~rst_out) + 3'd1)) != 3'b000) begin
            errors++;
            $display("FAIL release_order: rst_out=%b not released low-bit first", rst_out);
        end
        prev_fail = fail;
        prev_rout = rst_out;
    end

    initial begin
        int n;
        bit seen;

        reset       = 1'b1;
        mmcm_locked = 1'b0;

        // Normal start-up
        add("t1_reset",        1, 0,  3, 1, 3'b111, 0, 0, 0);
        add("t1_hold",         0, 0,  3, 1, 3'b111, 0, 0, 0);
        add("t1_rst_fall",     0, 0,  1, 0, 3'b111, 0, 0, 0);
        add("t1_wait",         0, 0,  5, 0, 3'b111, 0, 0, 0);
        add("t1_lock_stable",  0, 1, 10, 0, 3'b111, 0, 0, 0);
        add("t1_rel_b0",       0, 1,  1, 0, 3'b110, 0, 0, 0);
        add("t1_rel_b0_hold",  0, 1,  4, 0, 3'b110, 0, 0, 0);
        add("t1_rel_b1",       0, 1,  1, 0, 3'b100, 0, 0, 0);
        add("t1_rel_b1_hold",  0, 1,  4, 0, 3'b100, 0, 0, 0);
        add("t1_rel_b2",       0, 1,  1, 0, 3'b000, 0, 0, 0);
        add("t1_ready",        0, 1,  1, 0, 3'b000, 1, 0, 0);
        add("t1_run",          0, 1, 10, 0, 3'b000, 1, 0, 0);
        // Lock loss in RUN and re-sequence
        add("t4_loss_sync",    0, 0,  2, 0, 3'b000, 1, 0, 0);
        add("t4_loss_rst",     0, 0,  1, 1, 3'b111, 0, 0, 0);
        add("t4_hold",         0, 0,  3, 1, 3'b111, 0, 0, 0);
        add("t4_wait",         0, 0,  1, 0, 3'b111, 0, 0, 0);
        add("t4_relock",       0, 1, 10, 0, 3'b111, 0, 0, 0);
        add("t4_rel_b0",       0, 1,  1, 0, 3'b110, 0, 0, 0);
        add("t4_rel_b2",       0, 1, 10, 0, 3'b000, 0, 0, 0);
        add("t4_ready",        0, 1,  1, 0, 3'b000, 1, 0, 0);
        // One-cycle glitch at STABLE cnt=5
        add("t3_reset",        1, 0,  2, 1, 3'b111, 0, 0, 0);
        add("t3_to_wait",      0, 0,  4, 0, 3'b111, 0, 0, 0);
        add("t3_stable5",      0, 1,  8, 0, 3'b111, 0, 0, 0);
        add("t3_glitch",       0, 0,  1, 0, 3'b111, 0, 0, 0);
        add("t3_restable",     0, 1, 10, 0, 3'b111, 0, 0, 0);
        add("t3_rel_b0",       0, 1,  1, 0, 3'b110, 0, 0, 0);
        add("t3_rel_b2",       0, 1, 10, 0, 3'b000, 0, 0, 0);
        add("t3_ready",        0, 1,  1, 0, 3'b000, 1, 0, 0);
        // Lock loss mid-RELEASE, then a timeout and reset mid-WAIT_LOCK
        add("t5_reset",        1, 0,  2, 1, 3'b111, 0, 0, 0);
        add("t5_to_wait",      0, 0,  4, 0, 3'b111, 0, 0, 0);
        add("t5_rel_b0",       0, 1, 11, 0, 3'b110, 0, 0, 0);
        add("t5_loss_sync",    0, 0,  2, 0, 3'b110, 0, 0, 0);
        add("t5_loss_rst",     0, 0,  1, 1, 3'b111, 0, 0, 0);
        add("t5_hold",         0, 0,  3, 1, 3'b111, 0, 0, 0);
        add("t5_wait",         0, 0,  1, 0, 3'b111, 0, 0, 0);
        add("t5_timeout_pre",  0, 0, 19, 0, 3'b111, 0, 0, 0);
        add("t5_timeout",      0, 0,  1, 1, 3'b111, 0, 0, 1);
        add("t5_hold2",        0, 0,  3, 1, 3'b111, 0, 0, 1);
        add("t5_wait2",        0, 0,  1, 0, 3'b111, 0, 0, 1);
        add("t5_wait2_mid",    0, 0,  3, 0, 3'b111, 0, 0, 1);
        add("t5_reset_mid",    1, 0,  1, 1, 3'b111, 0, 0, 0);
        // Lock never arrives: retries exhausted
        add("t2_reset",        1, 0,  2, 1, 3'b111, 0, 0, 0);
        add("t2_hold1",        0, 0,  3, 1, 3'b111, 0, 0, 0);
        add("t2_wait1",        0, 0,  1, 0, 3'b111, 0, 0, 0);
        add("t2_wait1_end",    0, 0, 19, 0, 3'b111, 0, 0, 0);
        add("t2_retry1",       0, 0,  1, 1, 3'b111, 0, 0, 1);
        add("t2_hold2",        0, 0,  3, 1, 3'b111, 0, 0, 1);
        add("t2_wait2",        0, 0,  1, 0, 3'b111, 0, 0, 1);
        add("t2_wait2_end",    0, 0, 19, 0, 3'b111, 0, 0, 1);
        add("t2_retry2",       0, 0,  1, 1, 3'b111, 0, 0, 2);
        add("t2_hold3",        0, 0,  3, 1, 3'b111, 0, 0, 2);
        add("t2_wait3",        0, 0,  1, 0, 3'b111, 0, 0, 2);
        add("t2_wait3_end",    0, 0, 19, 0, 3'b111, 0, 0, 2);
        add("t2_fail",         0, 0,  1, 1, 3'b111, 0, 1, 2);
        add("t2_fail_sticky",  0, 1, 30, 1, 3'b111, 0, 1, 2);
        add("t2_reset_clear",  1, 0,  1, 1, 3'b111, 0, 0, 0);
        add("t2_restart_hold", 0, 0,  3, 1, 3'b111, 0, 0, 0);
        add("t2_restart_wait", 0, 0,  1, 0, 3'b111, 0, 0, 0);

        foreach (vecs[k]) begin
            reset       = vecs[k].rst;
            mmcm_locked = vecs[k].lk;
            repeat (vecs[k].cycles) @(posedge clk);
            @(negedge clk);
            check(vecs[k].name,
                  pack_out(mmcm_rst, rst_out, ready, fail, retry_cnt),
                  pack_out(vecs[k].mrst, vecs[k].rout, vecs[k].rdy, vecs[k].fl, vecs[k].rc));
        end

        // Lock already present when reset releases: ready after 4 HOLD + 1 WAIT
        // + 8 STABLE + 11 RELEASE edges.
        reset       = 1'b1;
        mmcm_locked = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n     = 0;
        seen  = 1'b0;
        for (int c = 1; c <= 200 && !seen; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready) begin
                seen = 1'b1;
                n    = c;
            end
        end
        check("seq_ready_seen", 32'(seen), 32'd1);
        check("seq_ready_latency", 32'(n), 32'd24);
        check("seq_run_outputs",
              pack_out(mmcm_rst, rst_out, ready, fail, retry_cnt),
              pack_out(1'b0, 3'b000, 1'b1, 1'b0, 8'd0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
